// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, using two line buffers.
// Optional frame_done pulse is enabled by defining WINDOW_FRAME_DONE_EN.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  input  logic        sof,
  output logic [71:0] window_out,
`ifdef WINDOW_FRAME_DONE_EN
  output logic        window_valid,
  output logic        frame_done
`else
  output logic        window_valid
`endif
);

  localparam int DATA_W = 8;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic [DATA_W-1:0] lb0 [IMG_WIDTH];   // line r-1
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];   // line r-2

  // Window columns stored as {bottom, middle, top}; col1 is c-1, col2 is c-2.
  logic [3*DATA_W-1:0] col1_p0, col2_p0;

  logic                accept, emit, last;
  logic [RW-1:0]       pos_r;
  logic [CW-1:0]       pos_c;
  logic [3*DATA_W-1:0] new_col;
  logic [71:0]         win_next;

  always_comb begin
    accept   = pixel_valid && (sof || state != IDLE);
    pos_r    = sof ? '0 : row;
    pos_c    = sof ? '0 : col;
    last     = (pos_r == LAST_R) && (pos_c == LAST_C);
    emit     = accept && !sof && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
    new_col  = {pixel_in, lb0[pos_c], lb1[pos_c]};
    win_next = {new_col[23:16], col1_p0[23:16], col2_p0[23:16],
                new_col[15:8],  col1_p0[15:8],  col2_p0[15:8],
                new_col[7:0],   col1_p0[7:0],   col2_p0[7:0]};
  end

  // Stage p0 -> p1: line buffers and column shift register (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pos_c] <= lb0[pos_c];
      lb0[pos_c] <= pixel_in;
      col2_p0    <= col1_p0;
      col1_p0    <= new_col;
    end
  end

  // Stage p1: position tracking, state machine and registered window outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      window_valid <= 1'b0;
      window_out   <= '0;
`ifdef WINDOW_FRAME_DONE_EN
      frame_done   <= 1'b0;
`endif
    end else begin
      window_valid <= emit;
      if (emit) window_out <= win_next;
`ifdef WINDOW_FRAME_DONE_EN
      frame_done   <= emit && last;
`endif
      if (accept) begin
        if (last) begin
          row <= '0;
          col <= '0;
        end else if (pos_c == LAST_C) begin
          row <= pos_r + RW'(1);
          col <= '0;
        end else begin
          row <= pos_r;
          col <= pos_c + CW'(1);
        end

        if (sof) begin
          state <= FILL;
        end else begin
          case (state)
            FILL:    if (pos_r == RW'(2) && pos_c == '0) state <= ACTIVE;
            ACTIVE:  if (last) state <= IDLE;
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen with a 4x4 image, pixel value = base + 4r + c.
// Define WINDOW_FRAME_DONE_EN for both files to exercise frame_done.
module tb_window_3x3_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        sof;
  logic [71:0] window_out;
  logic        window_valid;
`ifdef WINDOW_FRAME_DONE_EN
  logic        frame_done;
`endif

  int total = 0;
  int bad   = 0;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .sof          (sof),
    .window_out   (window_out),
`ifdef WINDOW_FRAME_DONE_EN
    .window_valid (window_valid),
    .frame_done   (frame_done)
`else
    .window_valid (window_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the accepting edge.
  task automatic send_pix(input logic v, input logic s, input logic [7:0] pix);
    @(negedge clk);
    pixel_valid = v;
    sof         = s;
    pixel_in    = pix;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] e;
    for (int k = 0; k < 9; k++)
      e[8*k +: 8] = 8'(base + 4 * (r - 2 + k / 3) + (c - 2 + k % 3));
    return e;
  endfunction

  // Full 4x4 frame with sof on pixel 0; optional idle cycle after each pixel.
  task automatic send_frame(input int base, input bit gap, output int nwin,
                            output int nfd, output logic [71:0] first);
    logic [71:0] held;
    nwin  = 0;
    nfd   = 0;
    first = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send_pix(1'b1, (r == 0 && c == 0), 8'(base + 4 * r + c));
        chk($sformatf("wv_r%0d_c%0d", r, c), 72'(window_valid), 72'(r >= 2 && c >= 2));
        if (window_valid) begin
          if (nwin == 0) first = window_out;
          nwin++;
          chk($sformatf("win_r%0d_c%0d", r, c), window_out, exp_win(base, r, c));
        end
`ifdef WINDOW_FRAME_DONE_EN
        chk($sformatf("fd_r%0d_c%0d", r, c), 72'(frame_done), 72'(r == 3 && c == 3));
        if (frame_done) nfd++;
`endif
        if (gap) begin
          held = window_out;
          send_pix(1'b0, 1'b0, 8'hEE);
          chk("gap_wv", 72'(window_valid), 72'd0);
          chk("gap_hold", window_out, held);
        end
      end
    end
  endtask

  int          nwin, nfd, fd_total;
  logic [71:0] first;

  initial begin
    rst_n = 1'b0; pixel_valid = 1'b0; sof = 1'b0; pixel_in = '0;
    fd_total = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wv", 72'(window_valid), 72'd0);
    chk("rst_wo", window_out, 72'd0);
`ifdef WINDOW_FRAME_DONE_EN
    chk("rst_fd", 72'(frame_done), 72'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Pixels without sof while idle are ignored.
    for (int i = 0; i < 5; i++) begin
      send_pix(1'b1, 1'b0, 8'(40 + i));
      chk("idle_ignore", 72'(window_valid), 72'd0);
    end

    // Continuous frame, then a back-to-back frame.
    send_frame(0, 1'b0, nwin, nfd, first);
    chk("f1_count", 72'(nwin), 72'd4);
    chk("f1_first", first, 72'h0A_09_08_06_05_04_02_01_00);
    fd_total += nfd;
    send_frame(0, 1'b0, nwin, nfd, first);
    chk("f2_count", 72'(nwin), 72'd4);
    chk("f2_first", first, 72'h0A_09_08_06_05_04_02_01_00);
    fd_total += nfd;
`ifdef WINDOW_FRAME_DONE_EN
    chk("fd_twice", 72'(fd_total), 72'd2);
`endif

    // Gapped frame.
    send_frame(0, 1'b1, nwin, nfd, first);
    chk("gap_count", 72'(nwin), 72'd4);
    chk("gap_first", first, 72'h0A_09_08_06_05_04_02_01_00);

    // Frame A aborted by sof at pixel 9, then full frame B.
    for (int i = 0; i < 9; i++) begin
      send_pix(1'b1, (i == 0), 8'(i));
      chk("fa_nowin", 72'(window_valid), 72'd0);
    end
    for (int i = 9; i < 12; i++) begin
      send_pix(1'b1, (i == 9), 8'(i));
      chk("fa_restart_nowin", 72'(window_valid), 72'd0);
    end
    send_frame(100, 1'b0, nwin, nfd, first);
    chk("fb_count", 72'(nwin), 72'd4);
    chk("fb_first", first, 72'h6E_6D_6C_6A_69_68_66_65_64);

    // Reset after pixel 11.
    for (int i = 0; i < 12; i++) send_pix(1'b1, (i == 0), 8'(i));
    chk("pre_rst_wv", 72'(window_valid), 72'd1);
    chk("pre_rst_wo", window_out, exp_win(0, 2, 3));
    @(negedge clk);
    pixel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wv", 72'(window_valid), 72'd0);
    chk("mid_rst_wo", window_out, 72'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 12; i < 16; i++) begin
      send_pix(1'b1, 1'b0, 8'(i));
      chk("post_rst_ignore", 72'(window_valid), 72'd0);
    end
    send_frame(0, 1'b0, nwin, nfd, first);
    chk("post_rst_count", 72'(nwin), 72'd4);
    chk("post_rst_first", first, 72'h0A_09_08_06_05_04_02_01_00);

    send_pix(1'b0, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
